// File: rtl/uart_cmd_paddle.sv
// uart_cmd_paddle: decodes UART command bytes into two paddle motion FSMs with hold timers, pause and restart.
// Ports:
//   clk        - single clock
//   reset      - synchronous, active-low reset
//   byte_in    - received byte, valid when byte_valid=1
//   byte_valid - one-cycle strobe qualifying byte_in
//   frame_tick - one-cycle strobe per video frame
//   paddle_l   - left paddle position (registered)
//   paddle_r   - right paddle position (registered)
//   pause      - game paused level (registered)
//   restart    - one-cycle restart pulse (registered)
//   cmd_err    - one-cycle pulse on an unrecognised byte (registered)
module uart_cmd_paddle #(
    parameter int PADDLE_MIN  = 0,
    parameter int PADDLE_MAX  = 400,
    parameter int STEP        = 4,
    parameter int HOLD_FRAMES = 8,
    parameter int Y_INIT      = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       frame_tick,
    output logic [9:0] paddle_l,
    output logic [9:0] paddle_r,
    output logic       pause,
    output logic       restart,
    output logic       cmd_err
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t     st_l, st_r;
    logic [3:0] hold_l, hold_r;
    logic [7:0] cmd;

    // Only upper-case letters are folded; other codes compare as received.
    always_comb cmd = (byte_in >= 8'h41 && byte_in <= 8'h5A) ? (byte_in | 8'h20) : byte_in;

    // Saturating step in 11 bits so pos+STEP cannot wrap before the limit check.
    function automatic logic [9:0] step_pos(input logic [9:0] pos, input state_t st);
        logic [10:0] p;
        p = {1'b0, pos};
        if (st == UP)
            return (p + 11'(STEP) > 11'(PADDLE_MAX)) ? 10'(PADDLE_MAX) : 10'(p + 11'(STEP));
        if (st == DOWN)
            return (p < 11'(PADDLE_MIN + STEP)) ? 10'(PADDLE_MIN) : 10'(p - 11'(STEP));
        return pos;
    endfunction

    // Movement is applied first; a command in the same cycle is assigned later
    // and therefore overrides the movement's state/hold update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            paddle_l <= 10'(Y_INIT);
            paddle_r <= 10'(Y_INIT);
            st_l     <= IDLE;
            st_r     <= IDLE;
            hold_l   <= 4'd0;
            hold_r   <= 4'd0;
            pause    <= 1'b0;
            restart  <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            restart <= 1'b0;
            cmd_err <= 1'b0;
            if (frame_tick && !pause) begin
                if (st_l != IDLE) begin
                    paddle_l <= step_pos(paddle_l, st_l);
                    hold_l   <= (hold_l == 4'd0) ? 4'd0 : hold_l - 4'd1;
                    if (hold_l <= 4'd1) st_l <= IDLE;
                end
                if (st_r != IDLE) begin
                    paddle_r <= step_pos(paddle_r, st_r);
                    hold_r   <= (hold_r == 4'd0) ? 4'd0 : hold_r - 4'd1;
                    if (hold_r <= 4'd1) st_r <= IDLE;
                end
            end
            if (byte_valid) begin
                case (cmd)
                    8'h77: begin st_l <= UP;   hold_l <= 4'(HOLD_FRAMES); end
                    8'h73: begin st_l <= DOWN; hold_l <= 4'(HOLD_FRAMES); end
                    8'h6F: begin st_r <= UP;   hold_r <= 4'(HOLD_FRAMES); end
                    8'h6C: begin st_r <= DOWN; hold_r <= 4'(HOLD_FRAMES); end
                    8'h78: begin
                        st_l   <= IDLE;
                        st_r   <= IDLE;
                        hold_l <= 4'd0;
                        hold_r <= 4'd0;
                    end
                    8'h70: pause <= ~pause;
                    8'h72: begin
                        paddle_l <= 10'(Y_INIT);
                        paddle_r <= 10'(Y_INIT);
                        st_l     <= IDLE;
                        st_r     <= IDLE;
                        hold_l   <= 4'd0;
                        hold_r   <= 4'd0;
                        pause    <= 1'b0;
                        restart  <= 1'b1;
                    end
                    default: cmd_err <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_paddle.sv
// tb_uart_cmd_paddle: directed self-checking bench for uart_cmd_paddle (main instance plus two instances near the limits).
module tb_uart_cmd_paddle;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] paddle_l, paddle_r, hi_l, hi_r, lo_l, lo_r;
    logic       pause, restart, cmd_err;
    logic       hi_pause, hi_restart, hi_err, lo_pause, lo_restart, lo_err;
    int         passed = 0;
    int         total = 0;

    uart_cmd_paddle dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_tick(frame_tick), .paddle_l(paddle_l), .paddle_r(paddle_r),
        .pause(pause), .restart(restart), .cmd_err(cmd_err)
    );

    uart_cmd_paddle #(.Y_INIT(398)) dut_hi (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_tick(frame_tick), .paddle_l(hi_l), .paddle_r(hi_r),
        .pause(hi_pause), .restart(hi_restart), .cmd_err(hi_err)
    );

    uart_cmd_paddle #(.Y_INIT(2)) dut_lo (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_tick(frame_tick), .paddle_l(lo_l), .paddle_r(lo_r),
        .pause(lo_pause), .restart(lo_restart), .cmd_err(lo_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Apply one cycle of stimulus between falling edges; outputs are sampled at the
    // falling edge after the capturing rising edge.
    task automatic drive(input logic bv, input logic [7:0] b, input logic ft, input logic rst);
        @(negedge clk);
        byte_valid = bv;
        byte_in    = b;
        frame_tick = ft;
        reset      = rst;
        @(negedge clk);
        byte_valid = 1'b0;
        frame_tick = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b1);
    endtask

    task automatic tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        // Reset overrides a simultaneous command and frame tick.
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        check("rst_l", paddle_l, 200);
        check("rst_r", paddle_r, 200);
        check("rst_pause", pause, 0);
        check("rst_restart", restart, 0);
        check("rst_err", cmd_err, 0);
        tick();
        check("rst_no_motion", paddle_l, 200);

        // Upper saturation on the instance starting at 398.
        send(8'h6F);
        check("hi_cmd_r", hi_r, 398);
        tick();
        check("hi_tick1_r", hi_r, 400);
        check("main_tick1_r", paddle_r, 204);
        tick();
        check("hi_tick2_r", hi_r, 400);
        check("main_tick2_r", paddle_r, 208);
        send(8'h72);
        check("rst_cmd_pulse", restart, 1);
        check("rst_cmd_r", paddle_r, 200);
        check("rst_cmd_hi_r", hi_r, 398);
        @(negedge clk);
        check("rst_cmd_pulse_end", restart, 0);

        // Lower saturation on the instance starting at 2.
        send(8'h73);
        tick();
        check("lo_tick1_l", lo_l, 0);
        check("main_down_l", paddle_l, 196);
        tick();
        check("lo_tick2_l", lo_l, 0);
        send(8'h72);
        check("lo_restart_l", lo_l, 2);

        // Right paddle down.
        send(8'h6C);
        tick();
        check("r_down", paddle_r, 196);
        send(8'h72);

        // Move and expire: 8 steps of 4, then hold.
        send(8'h77);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("expire_tick%0d", i), paddle_l, 200 + 4 * (i <= 8 ? i : 8));
        end

        // Idle command stops motion.
        send(8'h77);
        tick();
        check("w_again", paddle_l, 236);
        send(8'h78);
        tick();
        check("x_stops", paddle_l, 236);

        // Upper-case fold and an unrecognised letter.
        send(8'h57);
        tick();
        check("upper_W", paddle_l, 240);
        send(8'h41);
        check("err_pulse", cmd_err, 1);
        check("err_pos", paddle_l, 240);
        @(negedge clk);
        check("err_pulse_end", cmd_err, 0);
        tick();
        check("err_state_kept", paddle_l, 244);
        send(8'h78);

        // byte_in without byte_valid is ignored.
        drive(1'b0, 8'h72, 1'b0, 1'b1);
        check("no_valid_restart", restart, 0);
        check("no_valid_err", cmd_err, 0);

        // Pause freezes motion; restart clears pause.
        send(8'h70);
        check("pause_on", pause, 1);
        send(8'h77);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("paused_tick%0d", i), paddle_l, 244);
        end
        check("pause_held", pause, 1);
        send(8'h72);
        check("restart_l", paddle_l, 200);
        check("restart_pause", pause, 0);
        check("restart_pulse", restart, 1);
        @(negedge clk);
        check("restart_pulse_end", restart, 0);
        tick();
        check("restart_idle", paddle_l, 200);

        // Bring left paddle to 300 while moving up.
        for (int i = 0; i < 25; i++) begin
            send(8'h77);
            tick();
        end
        check("reach_300", paddle_l, 300);

        // Simultaneous command and tick: move from old state, then run DOWN for 8.
        drive(1'b1, 8'h73, 1'b1, 1'b1);
        check("simul_l", paddle_l, 304);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("simul_down%0d", i), paddle_l, i <= 8 ? 304 - 4 * i : 272);
        end

        // Reset mid-move abandons the motion.
        send(8'h6F);
        tick();
        check("premove_r", paddle_r, 204);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("midrst_l", paddle_l, 200);
        check("midrst_r", paddle_r, 200);
        check("midrst_pause", pause, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("postrst_r%0d", i), paddle_r, 200);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_cmd_paddle.md
UART_CMD_PADDLE -- requirements
Module: uart_cmd_paddle

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PADDLE_MIN, 0: lowest paddle position.
- PADDLE_MAX, 400: highest paddle position.
- STEP, 4: position change per frame tick.
- HOLD_FRAMES, 8: frame ticks a move command stays active.
- Y_INIT, 200: position after reset or restart.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-low reset.
- byte_in, in, 8: received byte from the upstream UART receiver.
- byte_valid, in, 1: one-cycle strobe; byte_in is valid in this cycle.
- frame_tick, in, 1: one-cycle strobe, once per video frame.
- paddle_l, out, 10: left paddle position.
- paddle_r, out, 10: right paddle position.
- pause, out, 1: level; game paused.
- restart, out, 1: one-cycle pulse; game restart.
- cmd_err, out, 1: one-cycle pulse; unrecognised byte.
REQ-003 All outputs SHALL be registered on the rising edge of clk.

Function
REQ-004 A byte SHALL be decoded only in a cycle where byte_valid=1; byte_in SHALL be ignored in all other cycles.
REQ-005 Decoding SHALL be case-insensitive: bit 5 is forced to 1 before comparison, but only for letter codes 0x41-0x5A.
REQ-006 Command map after folding:
- 0x77 'w': left paddle UP.
- 0x73 's': left paddle DOWN.
- 0x6F 'o': right paddle UP.
- 0x6C 'l': right paddle DOWN.
- 0x78 'x': both paddles IDLE.
- 0x70 'p': toggle pause.
- 0x72 'r': restart.
REQ-007 Any other byte SHALL produce cmd_err=1 in the next cycle and SHALL change no other state.
REQ-008 Each paddle SHALL have its own FSM with states IDLE, UP and DOWN, plus a 4-bit hold counter.
REQ-009 A move command SHALL place that paddle's FSM in the commanded state and load its hold counter with HOLD_FRAMES.
- A repeated command reloads the counter.
- The opposite command switches direction immediately and reloads the counter.
REQ-010 On frame_tick with pause=0, each paddle in UP or DOWN SHALL:
- change position by +STEP (UP) or -STEP (DOWN), then
- decrement its hold counter.
When the counter reaches 0, the FSM SHALL return to IDLE in the same update.
REQ-011 Position arithmetic SHALL use 11-bit intermediates and saturate:
- UP: if pos+STEP > PADDLE_MAX, the result is PADDLE_MAX.
- DOWN: if pos < PADDLE_MIN+STEP, the result is PADDLE_MIN.
- Hitting a limit SHALL NOT return the FSM to IDLE early; the hold count continues.
REQ-012 While pause=1, frame_tick SHALL be ignored: positions and hold counters are frozen, and FSM states remain settable by commands.
REQ-013 If byte_valid and frame_tick occur in the same cycle:
- Movement SHALL use the pre-command FSM state and position.
- The command's FSM and hold-counter update SHALL override the movement's hold/state update.
REQ-014 Restart ('r') SHALL, in the next cycle:
- set both positions to Y_INIT,
- set both FSMs to IDLE and hold counters to 0,
- set pause=0,
- assert restart=1 for exactly one cycle.
Restart also takes priority over a simultaneous frame_tick.
REQ-015 The 'p' command SHALL toggle pause, visible in the next cycle.
REQ-016 Latency SHALL be exactly one cycle from a byte_valid or frame_tick edge to the updated outputs.
REQ-017 cmd_err and restart SHALL never be asserted for more than one cycle per byte_valid.

Reset
REQ-018 With reset=0 at a rising clk edge, the block SHALL set:
- paddle_l = paddle_r = Y_INIT,
- pause=0, restart=0, cmd_err=0,
- both FSMs IDLE, hold counters 0.
This overrides byte_valid and frame_tick in the same cycle.
REQ-019 Reset asserted mid-move SHALL abandon the move; no residual motion SHALL occur after reset is released.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Move and expire: 'w', then 10 frame_ticks -> paddle_l steps 200 to 232 over 8 ticks, then holds at 232; FSM IDLE.
- Upper saturation: from paddle_r=398, 'o', then 2 frame_ticks -> paddle_r=400, 400.
- Lower saturation: from paddle_l=2, 's', then 1 frame_tick -> paddle_l=0.
- Case and errors: 'W' (0x57) -> same as 'w'. Byte 0x41 'A' -> cmd_err pulse of 1 cycle, positions unchanged.
- Pause and restart: 'p', 'w', 3 frame_ticks -> paddle_l unchanged, pause=1. Then 'r' -> paddle_l=200, pause=0, restart pulse of 1 cycle.
- Simultaneous and reset: byte_valid ('s') with frame_tick while the left paddle is UP at 300 -> paddle_l=304 and FSM DOWN with hold 8. Then reset=0 for 1 cycle during motion -> all outputs at reset values, with no further motion on later frame_ticks.
